// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES round sequencer and its round-constant generator.
package aes_pkg;

    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_256 = 14;

    typedef logic [7:0] aes_byte_t;

    typedef enum logic [1:0] {
        M128 = 2'b00,
        M256 = 2'b10
    } key_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSUB,
        KWAIT,
        DSUB,
        DWAIT,
        DONE
    } seq_state_e;

    // Registered control strobes driven to the key-gen, S-box and enc datapaths.
    typedef struct packed {
        logic zero_rnd;
        logic final_rnd;
        logic key_sel;
        logic en_rnd;
        logic key_sub;
        logic en_key;
        logic gen_key;
        logic next_rnd;
        logic kstep_type;
        logic out_valid;
        logic busy;
    } seq_strobe_t;

    // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loads 0x01 on init, steps by xtime on advance.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       init_i,
    input  logic       adv_i,
    output logic [7:0] rcon_o
);

    aes_byte_t rcon_q;
    aes_byte_t rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (init_i) begin
            rcon_d = 8'h01;
        end else if (adv_i) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            rcon_q <= 8'h01;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_seq.sv
// AES-128/256 round sequencer: sequences key expansion and data rounds through one
// shared, SBOX_LAT-deep S-box and issues control strobes to the external datapath.
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_LAT = 1,
    parameter int unsigned MAX_NR   = 14
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] mode_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       busy_o,
    output logic       err_o,
    output logic       zero_rnd_o,
    output logic       final_rnd_o,
    output logic       key_sel_o,
    output logic       en_rnd_o,
    output logic       key_sub_o,
    output logic       en_key_o,
    output logic       gen_key_o,
    output logic       next_rnd_o,
    output logic       kstep_type_o,
    output logic [7:0] rcon_o,
    output logic [3:0] rnd_cnt_o
);

    localparam int unsigned RND_W  = $clog2(MAX_NR + 1);
    localparam int unsigned WCNT_W = 2;

    seq_state_e        state_q, state_d;
    logic              is256_q, is256_d;
    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    seq_strobe_t       strb_q, strb_d;
    logic              err_q, err_d;

    logic             accept;
    logic             mode_ok;
    logic             wait_last;
    logic             rcon_init;
    logic             rcon_adv;
    logic [RND_W-1:0] nr_q;
    logic [RND_W-1:0] nr_d;

    assign in_ready_o = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
    assign accept     = in_valid_i & in_ready_o;
    assign mode_ok    = (mode_i == M128) | (mode_i == M256);
    assign wait_last  = (wcnt_q == WCNT_W'(SBOX_LAT - 1));
    assign nr_q       = is256_q ? RND_W'(NR_256) : RND_W'(NR_128);
    assign nr_d       = is256_d ? RND_W'(NR_256) : RND_W'(NR_128);

    // Next-state: INIT, then per round an optional key phase followed by a data phase.
    always_comb begin
        state_d   = state_q;
        is256_d   = is256_q;
        rnd_d     = rnd_q;
        wcnt_d    = wcnt_q;
        err_d     = 1'b0;
        rcon_init = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (mode_ok) begin
                        state_d   = INIT;
                        is256_d   = (mode_i == M256);
                        rnd_d     = '0;
                        rcon_init = 1'b1;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if ((state_q == DONE) && out_ready_i) begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                rnd_d   = RND_W'(1);
                wcnt_d  = '0;
                state_d = is256_q ? DSUB : KSUB;
            end
            KSUB: begin
                wcnt_d  = '0;
                state_d = KWAIT;
            end
            KWAIT: begin
                if (wait_last) begin
                    state_d = DSUB;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            DSUB: begin
                wcnt_d  = '0;
                state_d = DWAIT;
            end
            DWAIT: begin
                if (wait_last) begin
                    if (rnd_q == nr_q) begin
                        state_d = DONE;
                    end else begin
                        rnd_d   = rnd_q + RND_W'(1);
                        state_d = KSUB;
                    end
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave the block registered.
    always_comb begin
        strb_d = '0;
        case (state_d)
            INIT: begin
                strb_d.busy     = 1'b1;
                strb_d.gen_key  = 1'b1;
                strb_d.en_key   = 1'b1;
                strb_d.en_rnd   = 1'b1;
                strb_d.zero_rnd = 1'b1;
            end
            KSUB: begin
                strb_d.busy       = 1'b1;
                strb_d.key_sub    = 1'b1;
                strb_d.kstep_type = is256_d & rnd_d[0];
            end
            KWAIT: begin
                strb_d.busy       = 1'b1;
                strb_d.kstep_type = is256_d & rnd_d[0];
                if (wcnt_d == WCNT_W'(SBOX_LAT - 1)) begin
                    strb_d.en_key   = 1'b1;
                    strb_d.next_rnd = 1'b1;
                end
            end
            DSUB: begin
                strb_d.busy    = 1'b1;
                strb_d.key_sel = is256_d & (rnd_d == RND_W'(1));
            end
            DWAIT: begin
                strb_d.busy    = 1'b1;
                strb_d.key_sel = is256_d & (rnd_d == RND_W'(1));
                if (wcnt_d == WCNT_W'(SBOX_LAT - 1)) begin
                    strb_d.en_rnd    = 1'b1;
                    strb_d.final_rnd = (rnd_d == nr_d);
                end
            end
            DONE: begin
                strb_d.out_valid = 1'b1;
            end
            default: strb_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q <= IDLE;
            is256_q <= 1'b0;
            rnd_q   <= '0;
            wcnt_q  <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            is256_q <= is256_d;
            rnd_q   <= rnd_d;
            wcnt_q  <= wcnt_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
        end
    end

    // rcon steps only when a RotWord+SubWord+rcon key step commits.
    assign rcon_adv = strb_q.next_rnd & ~strb_q.kstep_type;

    aes_rcon_gen u_rcon (
        .clk    (clk),
        .nrst   (nrst),
        .init_i (rcon_init),
        .adv_i  (rcon_adv),
        .rcon_o (rcon_o)
    );

    assign out_valid_o  = strb_q.out_valid;
    assign busy_o       = strb_q.busy;
    assign err_o        = err_q;
    assign zero_rnd_o   = strb_q.zero_rnd;
    assign final_rnd_o  = strb_q.final_rnd;
    assign key_sel_o    = strb_q.key_sel;
    assign en_rnd_o     = strb_q.en_rnd;
    assign key_sub_o    = strb_q.key_sub;
    assign en_key_o     = strb_q.en_key;
    assign gen_key_o    = strb_q.gen_key;
    assign next_rnd_o   = strb_q.next_rnd;
    assign kstep_type_o = strb_q.kstep_type;
    assign rnd_cnt_o    = 4'(rnd_q);

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: per-cycle strobe schedule built from the round rules,
// table-driven and randomized blocks, plus reserved-mode, stall and reset-abort sequences.
module tb_aes_round_seq;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic [1:0] mode_i = 2'b00;
    logic       in_valid_i = 1'b0;
    logic       out_ready_i = 1'b0;
    logic       in_ready_o, out_valid_o, busy_o, err_o, zero_rnd_o, final_rnd_o;
    logic       key_sel_o, en_rnd_o, key_sub_o, en_key_o, gen_key_o, next_rnd_o, kstep_type_o;
    logic [7:0] rcon_o;
    logic [3:0] rnd_cnt_o;

    logic [1:0] mode3 = 2'b00;
    logic       v3 = 1'b0;
    logic       rdy3 = 1'b1;
    logic       ir3, ov3, bz3, er3, zr3, fr3, ks3, er_3, sub3, ek3, gk3, nr3, kt3;
    logic [7:0] rc3;
    logic [3:0] rn3;

    always #5 clk = ~clk;

    aes_round_seq #(.SBOX_LAT(1)) dut (
        .clk(clk), .nrst(nrst), .mode_i(mode_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .err_o(err_o), .zero_rnd_o(zero_rnd_o), .final_rnd_o(final_rnd_o),
        .key_sel_o(key_sel_o), .en_rnd_o(en_rnd_o), .key_sub_o(key_sub_o), .en_key_o(en_key_o),
        .gen_key_o(gen_key_o), .next_rnd_o(next_rnd_o), .kstep_type_o(kstep_type_o),
        .rcon_o(rcon_o), .rnd_cnt_o(rnd_cnt_o)
    );

    aes_round_seq #(.SBOX_LAT(3)) dut3 (
        .clk(clk), .nrst(nrst), .mode_i(mode3), .in_valid_i(v3),
        .in_ready_o(ir3), .out_valid_o(ov3), .out_ready_i(rdy3),
        .busy_o(bz3), .err_o(er3), .zero_rnd_o(zr3), .final_rnd_o(fr3),
        .key_sel_o(ks3), .en_rnd_o(er_3), .key_sub_o(sub3), .en_key_o(ek3),
        .gen_key_o(gk3), .next_rnd_o(nr3), .kstep_type_o(kt3),
        .rcon_o(rc3), .rnd_cnt_o(rn3)
    );

    typedef struct packed {
        logic       busy;
        logic       zero_rnd;
        logic       final_rnd;
        logic       key_sel;
        logic       en_rnd;
        logic       key_sub;
        logic       en_key;
        logic       gen_key;
        logic       next_rnd;
        logic       kstep;
        logic       out_valid;
        logic       err;
        logic [7:0] rcon;
        logic [3:0] rnd;
    } obs_t;

    typedef struct {
        logic [1:0] mode;
        int         stall;
        int         lat;
        logic [7:0] last_rc;
        bit         b2b;
    } vec_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    function automatic obs_t obs();
        obs_t o;
        o.busy = busy_o;       o.zero_rnd = zero_rnd_o; o.final_rnd = final_rnd_o;
        o.key_sel = key_sel_o; o.en_rnd = en_rnd_o;     o.key_sub = key_sub_o;
        o.en_key = en_key_o;   o.gen_key = gen_key_o;   o.next_rnd = next_rnd_o;
        o.kstep = kstep_type_o; o.out_valid = out_valid_o; o.err = err_o;
        o.rcon = rcon_o;       o.rnd = rnd_cnt_o;
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        logic [8:0] w;
        w = {b, 1'b0};
        if (w[8]) w = w ^ 9'h11b;
        return w[7:0];
    endfunction

    // Expected output per cycle after accept: INIT, rounds 1..Nr, then the first DONE cycle.
    function automatic void build(input bit is256, input int l);
        obs_t       r;
        logic [7:0] rc;
        int         nr;
        bit         odd_step;
        rc = 8'h01;
        nr = is256 ? 14 : 10;
        exp_q.delete();
        r = '0; r.busy = 1; r.gen_key = 1; r.en_key = 1; r.en_rnd = 1; r.zero_rnd = 1; r.rcon = rc;
        exp_q.push_back(r);
        for (int rn = 1; rn <= nr; rn++) begin
            if (!(is256 && rn == 1)) begin
                odd_step = is256 && (rn % 2 == 1);
                for (int p = 0; p <= l; p++) begin
                    r = '0; r.busy = 1; r.rnd = 4'(rn); r.rcon = rc; r.kstep = odd_step;
                    r.key_sub = (p == 0); r.en_key = (p == l); r.next_rnd = (p == l);
                    exp_q.push_back(r);
                end
                if (!odd_step) rc = xt(rc);
            end
            for (int p = 0; p <= l; p++) begin
                r = '0; r.busy = 1; r.rnd = 4'(rn); r.rcon = rc;
                r.key_sel = is256 && (rn == 1);
                r.en_rnd = (p == l); r.final_rnd = (p == l) && (rn == nr);
                exp_q.push_back(r);
            end
        end
        r = '0; r.out_valid = 1; r.rnd = 4'(nr); r.rcon = rc;
        exp_q.push_back(r);
    endfunction

    task automatic check_obs(input string name, input int cyc, input obs_t e);
        obs_t a;
        a = obs();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, a, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, a, e);
        end
    endtask

    task automatic start_block(input logic [1:0] m);
        mode_i = m; in_valid_i = 1'b1; out_ready_i = 1'b1;
        #1 check_int("in_ready_at_accept", int'(in_ready_o), 1);
        @(posedge clk);
    endtask

    // Runs one block to DONE, holds out_ready low for 'stall' extra cycles.
    task automatic run_block(input logic [1:0] m, input int stall, input int lat, input logic [7:0] last_rc);
        int         first;
        logic [7:0] seen_rc;
        int         n;
        first = -1; seen_rc = 8'h00;
        build(m == 2'b10, 1);
        n = exp_q.size();
        start_block(m);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_obs("trace", k + 1, exp_q[k]);
            if (first < 0 && out_valid_o) first = k + 1;
            if (key_sub_o) seen_rc = rcon_o;
            if (k < n - 1) begin
                in_valid_i = 1'($urandom); out_ready_i = 1'($urandom); mode_i = 2'($urandom);
            end else begin
                in_valid_i = 1'b0; out_ready_i = 1'b0;
            end
        end
        check_int("latency", first, lat);
        check_int("last_round_rcon", int'(seen_rc), int'(last_rc));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_obs("done_hold", n + s + 1, exp_q[n-1]);
            check_int("in_ready_in_stall", int'(in_ready_o), 0);
        end
    endtask

    task automatic finish_idle();
        obs_t e;
        out_ready_i = 1'b1; in_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        e = exp_q[$];
        e.out_valid = 1'b0;
        check_obs("idle", 0, e);
        check_int("in_ready_idle", int'(in_ready_o), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[4];
        obs_t rst_v;
        obs_t e;
        int   cnt;
        bit   is256;
        logic [1:0] m;

        tbl[0] = '{mode: 2'b00, stall: 5, lat: 42, last_rc: 8'h36, b2b: 1'b1};
        tbl[1] = '{mode: 2'b10, stall: 0, lat: 56, last_rc: 8'h40, b2b: 1'b0};
        tbl[2] = '{mode: 2'b10, stall: 3, lat: 56, last_rc: 8'h40, b2b: 1'b1};
        tbl[3] = '{mode: 2'b00, stall: 1, lat: 42, last_rc: 8'h36, b2b: 1'b0};

        rst_v = '0;
        rst_v.rcon = 8'h01;

        repeat (3) @(negedge clk);
        check_obs("reset_state", 0, rst_v);
        check_int("reset_in_ready", int'(in_ready_o), 1);
        nrst = 1'b0;

        // Reserved mode: one-cycle err, no strobes, ready again.
        @(negedge clk);
        mode_i = 2'b01; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        e = rst_v; e.err = 1'b1;
        check_obs("reserved_c1", 1, e);
        @(negedge clk);
        check_obs("reserved_c2", 2, rst_v);
        check_int("reserved_in_ready_c2", int'(in_ready_o), 1);

        for (int i = 0; i < 4; i++) begin
            run_block(tbl[i].mode, tbl[i].stall, tbl[i].lat, tbl[i].last_rc);
            if (!tbl[i].b2b) finish_idle();
        end

        for (int i = 0; i < 6; i++) begin
            is256 = 1'($urandom);
            m = is256 ? 2'b10 : 2'b00;
            run_block(m, int'($urandom_range(0, 3)),
                      2 + (is256 ? 14 : 10) * 2 * 2 - (is256 ? 2 : 0),
                      is256 ? 8'h40 : 8'h36);
            if (1'($urandom)) finish_idle();
        end
        finish_idle();

        // Reset in cycle 20 of an AES-128 block aborts it.
        build(1'b0, 1);
        start_block(2'b00);
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            check_obs("pre_abort", k + 1, exp_q[k]);
            in_valid_i = 1'b0; out_ready_i = 1'b0;
        end
        @(negedge clk);
        nrst = 1'b1;
        #1 check_obs("abort_reset", 20, rst_v);
        check_int("abort_in_ready", int'(in_ready_o), 1);
        @(negedge clk);
        nrst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid_o || busy_o) cnt++;
        end
        check_int("no_output_after_abort", cnt, 0);
        run_block(2'b00, 0, 42, 8'h36);
        finish_idle();

        // SBOX_LAT=3 instance: 8-cycle rounds, DONE in cycle 82.
        @(negedge clk);
        mode3 = 2'b00; v3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v3 = 1'b0;
        cnt = 1;
        while (!ov3 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check_int("lat3_aes128", cnt, 82);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
